// File: rtl/instr_fetch.sv
// instr_fetch: PC owner and imem requester feeding IF/ID with {pc+4, instr}; bubble is pc=0, instr=FFFFFFFF.
// Optional IFETCH_PERF_CNT_EN adds a saturating bubble-cycle counter on bubble_cnt_o.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [7:0]  MAX_WAIT = 8'd16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_ctrl_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic        fetch_err_o
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] bubble_cnt_o
`endif
);
  typedef enum logic [1:0] {REQ, HOLD, ERR} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, tgt_q, tgt_d, buf_q, buf_d;
  logic        discard_q, discard_d, valid;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] pc_inc, rpc;
  assign pc_inc = pc_q + 32'd4;
  assign rpc    = {redirect_pc_i[31:2], 2'b00};
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    buf_d     = buf_q;
    discard_d = discard_q;
    wait_d    = wait_q;
    valid     = 1'b0;
    case (state_q)
      REQ: begin
        if (imem_ack_i) begin
          wait_d    = 8'd0;
          discard_d = 1'b0;
          if (!discard_q && !redirect_i) begin
            valid = 1'b1;
            if (stall_ctrl_i) begin
              buf_d   = imem_data_i;
              state_d = HOLD;
            end else
              pc_d = pc_inc;
          end else
            pc_d = redirect_i ? rpc : tgt_q;
        end else begin
          // address must stay put while the request is outstanding, so park the target
          wait_d = wait_q + 8'd1;
          if (redirect_i) begin
            tgt_d     = rpc;
            discard_d = 1'b1;
          end
          if (MAX_WAIT != 8'd0 && wait_q == MAX_WAIT - 8'd1)
            state_d = ERR;
        end
      end
      HOLD: begin
        if (redirect_i) begin
          pc_d    = rpc;
          wait_d  = 8'd0;
          state_d = REQ;
        end else begin
          valid = 1'b1;
          if (!stall_ctrl_i) begin
            pc_d    = pc_inc;
            wait_d  = 8'd0;
            state_d = REQ;
          end
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= REQ;
      pc_q      <= RESET_PC;
      tgt_q     <= 32'd0;
      buf_q     <= 32'd0;
      discard_q <= 1'b0;
      wait_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tgt_q     <= tgt_d;
      buf_q     <= buf_d;
      discard_q <= discard_d;
      wait_q    <= wait_d;
    end
  end
  assign imem_req_o    = state_q == REQ;
  assign imem_addr_o   = pc_q;
  assign fetch_err_o   = state_q == ERR;
  assign instr_valid_o = valid & ~rst_i;
  assign pc_o          = instr_valid_o ? pc_inc : 32'd0;
  assign instr_o       = !instr_valid_o ? 32'hFFFF_FFFF : state_q == HOLD ? buf_q : imem_data_i;
`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      bubble_cnt_o <= 32'd0;
    else if (!instr_valid_o && state_q != ERR && bubble_cnt_o != 32'hFFFF_FFFF)
      bubble_cnt_o <= bubble_cnt_o + 32'd1;
  end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of instr_fetch (MAX_WAIT=4); memory returns addr ^ key.
module tb_instr_fetch;
  logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, redir = 1'b0, ack = 1'b1;
  logic [31:0] rpc = 32'd0, key = 32'd0;
  logic        req, valid, err;
  logic [31:0] addr, pc, instr, data;
  logic [98:0] obs, exp_v;
  int          errors = 0, checks = 0;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] bcnt;
`endif
  localparam logic [31:0] B = 32'hFFFF_FFFF;
  always #5 clk = ~clk;
  assign data = addr ^ key;
  assign obs  = {req, valid, err, addr, pc, instr};
  instr_fetch #(.RESET_PC(32'h0), .MAX_WAIT(8'd4)) dut (
    .clk_i(clk), .rst_i(rst), .stall_ctrl_i(stall), .redirect_i(redir), .redirect_pc_i(rpc),
    .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_data_i(data),
    .pc_o(pc), .instr_o(instr), .instr_valid_o(valid), .fetch_err_o(err)
`ifdef IFETCH_PERF_CNT_EN
    , .bubble_cnt_o(bcnt)
`endif
  );

  task test_reset;
    for (int i = 0; i < 2; i++) begin
      #1 exp_v = {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, B};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL reset%0d obs=%h exp=%h", i, obs, exp_v); end
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  task test_stream(input logic [31:0] base, input int n);
    ack = 1'b1; stall = 1'b0; redir = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1 exp_v = {1'b1, 1'b1, 1'b0, base + 32'(4*i), base + 32'(4*i+4), base + 32'(4*i)};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL stream_%h_%0d obs=%h exp=%h", base, i, obs, exp_v); end
      @(negedge clk);
    end
  endtask

  task test_late_ack;
    ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1 exp_v = {1'b1, 1'b0, 1'b0, 32'h10, 32'h0, B};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL late_wait%0d obs=%h exp=%h", i, obs, exp_v); end
      @(negedge clk);
    end
    ack = 1'b1;
    #1 exp_v = {1'b1, 1'b1, 1'b0, 32'h10, 32'h14, 32'h10};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL late_ack obs=%h exp=%h", obs, exp_v); end
    @(negedge clk);
  endtask

  task test_stall;
    ack = 1'b1; stall = 1'b1;
    #1 exp_v = {1'b1, 1'b1, 1'b0, 32'h20, 32'h24, 32'h20};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL stall_ack obs=%h exp=%h", obs, exp_v); end
    @(negedge clk);
    ack = 1'b0; key = 32'hA5A5_0000;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) stall = 1'b0;
      #1 exp_v = {1'b0, 1'b1, 1'b0, 32'h20, 32'h24, 32'h20};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL stall_hold%0d obs=%h exp=%h", i, obs, exp_v); end
      @(negedge clk);
    end
    key = 32'h0;
    #1 exp_v = {1'b1, 1'b0, 1'b0, 32'h24, 32'h0, B};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL stall_next obs=%h exp=%h", obs, exp_v); end
    @(negedge clk);
  endtask

  task test_redirect_pending;
    ack = 1'b0; redir = 1'b1; rpc = 32'h103;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) redir = 1'b0;
      if (i == 2) ack = 1'b1;
      #1 exp_v = {1'b1, 1'b0, 1'b0, 32'h30, 32'h0, B};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL redir_pend%0d obs=%h exp=%h", i, obs, exp_v); end
      @(negedge clk);
    end
    #1 exp_v = {1'b1, 1'b1, 1'b0, 32'h100, 32'h104, 32'h100};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL redir_target obs=%h exp=%h", obs, exp_v); end
    @(negedge clk);
  endtask

  task test_redirect_ack_hold;
    ack = 1'b1; redir = 1'b1; rpc = 32'h200;
    #1 exp_v = {1'b1, 1'b0, 1'b0, 32'h104, 32'h0, B};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL redir_ack obs=%h exp=%h", obs, exp_v); end
    @(negedge clk);
    redir = 1'b0; stall = 1'b1;
    #1 exp_v = {1'b1, 1'b1, 1'b0, 32'h200, 32'h204, 32'h200};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL redir_ack_tgt obs=%h exp=%h", obs, exp_v); end
    @(negedge clk);
    redir = 1'b1; rpc = 32'h301;
    #1 exp_v = {1'b0, 1'b0, 1'b0, 32'h200, 32'h0, B};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL redir_hold obs=%h exp=%h", obs, exp_v); end
    @(negedge clk);
    stall = 1'b0; rpc = 32'hFFFF_FFFF;
    #1 exp_v = {1'b1, 1'b0, 1'b0, 32'h300, 32'h0, B};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL redir_hold_tgt obs=%h exp=%h", obs, exp_v); end
    @(negedge clk);
  endtask

  task test_wrap;
    redir = 1'b0; ack = 1'b1;
    #1 exp_v = {1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL wrap_top obs=%h exp=%h", obs, exp_v); end
    @(negedge clk);
    #1 exp_v = {1'b1, 1'b1, 1'b0, 32'h0, 32'h4, 32'h0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL wrap_zero obs=%h exp=%h", obs, exp_v); end
    @(negedge clk);
  endtask

  task test_timeout;
    ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 exp_v = {1'b1, 1'b0, 1'b0, 32'h4, 32'h0, B};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL tmo_wait%0d obs=%h exp=%h", i, obs, exp_v); end
      @(negedge clk);
    end
    ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 exp_v = {1'b0, 1'b0, 1'b1, 32'h4, 32'h0, B};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL tmo_err%0d obs=%h exp=%h", i, obs, exp_v); end
      @(negedge clk);
    end
    rst = 1'b1; ack = 1'b0;
    #1 exp_v = {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, B};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL tmo_reset obs=%h exp=%h", obs, exp_v); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task test_perf_cnt;
    ack = 1'b0;
`ifdef IFETCH_PERF_CNT_EN
    #1 checks++;
    if (bcnt !== 32'd0) begin errors++; $display("FAIL cnt_reset got=%0d want=0", bcnt); end
`endif
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin ack = 1'b1; redir = 1'b1; rpc = 32'h40; end
      if (i == 4) begin ack = 1'b0; redir = 1'b0; end
      #1 exp_v = {1'b1, 1'b0, 1'b0, i == 4 ? 32'h40 : 32'h0, 32'h0, B};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL cnt_bubble%0d obs=%h exp=%h", i, obs, exp_v); end
      @(negedge clk);
    end
    test_stream(32'h40, 3);
`ifdef IFETCH_PERF_CNT_EN
    for (int i = 0; i < 2; i++) begin
      #1 checks++;
      if (bcnt !== 32'd5) begin errors++; $display("FAIL cnt_hold%0d got=%0d want=5", i, bcnt); end
      @(negedge clk);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_stream(32'h0, 4);
    test_late_ack;
    test_stream(32'h14, 3);
    test_stall;
    test_stream(32'h24, 3);
    test_redirect_pending;
    test_redirect_ack_hold;
    test_wrap;
    test_timeout;
    test_perf_cnt;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
